// File: rtl/hour_disp_drv.sv
// Hour display driver: registers a mod-12 hour code, tracks AM/PM on the 11->0 wrap,
// and scans two active-low 7-segment digits. Define HOUR_LEAD_BLANK_EN to blank a leading tens zero.
module hour_disp_drv #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hour_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       pm
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {SLOT_ONES = 1'b0, SLOT_TENS = 1'b1} slot_e;

  logic [3:0]    hour_q, hour_d;
  logic          pm_q, pm_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  slot_e         digit_sel_q, digit_sel_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [1:0]    an_q, an_d;

  logic [3:0]    tens_dig, ones_dig;
  logic [6:0]    tens_pat, ones_pat;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction

  // 12-hour mapping: code 0 reads "12", codes 12..15 show dashes on both digits.
  always_comb begin
    tens_dig = 4'd0;
    ones_dig = 4'd0;
    tens_pat = SEG_DASH;
    ones_pat = SEG_DASH;
    if (hour_q == 4'd0) begin
      tens_dig = 4'd1;
      ones_dig = 4'd2;
    end else if (hour_q <= 4'd9) begin
      tens_dig = 4'd0;
      ones_dig = hour_q;
    end else begin
      tens_dig = 4'd1;
      ones_dig = hour_q - 4'd10;
    end
    if (hour_q <= 4'd11) begin
      ones_pat = seg_enc(ones_dig);
`ifdef HOUR_LEAD_BLANK_EN
      tens_pat = (tens_dig == 4'd0) ? SEG_BLANK : seg_enc(tens_dig);
`else
      tens_pat = seg_enc(tens_dig);
`endif
    end
  end

  always_comb begin
    hour_d      = hour_in;
    pm_d        = pm_q ^ ((hour_q == 4'd11) && (hour_in == 4'd0));
    scan_cnt_d  = scan_cnt_q + CW'(1);
    digit_sel_d = digit_sel_q;
    if (scan_cnt_q == CNT_MAX) begin
      scan_cnt_d  = '0;
      digit_sel_d = (digit_sel_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
    end
    // dp follows the pre-edge pm, so a wrap shows on dp one edge after pm moves.
    if (digit_sel_q == SLOT_ONES) begin
      an_d  = 2'b10;
      seg_d = ones_pat;
      dp_d  = ~pm_q;
    end else begin
      an_d  = 2'b01;
      seg_d = tens_pat;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hour_q      <= '0;
      pm_q        <= 1'b0;
      scan_cnt_q  <= '0;
      digit_sel_q <= SLOT_ONES;
      seg_q       <= '1;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      hour_q      <= hour_d;
      pm_q        <= pm_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
  assign pm  = pm_q;

endmodule

// File: tb/tb_hour_disp_drv.sv
// Directed bench for hour_disp_drv: two instances (SCAN_DIV 4 and 1) driven in lockstep,
// expected outputs queued per edge from a digit-string model and compared half a cycle later.
module tb_hour_disp_drv;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] hour_in = 4'd0;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, pm_a, pm_b;
  logic [1:0] an_a, an_b;

  always #5 clk = ~clk;

  hour_disp_drv #(.SCAN_DIV(4)) u_a (
    .clk(clk), .reset(reset), .hour_in(hour_in),
    .seg(seg_a), .dp(dp_a), .an(an_a), .pm(pm_a)
  );

  hour_disp_drv #(.SCAN_DIV(1)) u_b (
    .clk(clk), .reset(reset), .hour_in(hour_in),
    .seg(seg_b), .dp(dp_b), .an(an_b), .pm(pm_b)
  );

  typedef struct {
    string       tag;
    int unsigned inst;
    logic [10:0] exp;   // {seg, dp, an, pm}
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int unsigned div_k [2] = '{4, 1};
  int unsigned m_hour[2];
  int unsigned m_cnt [2];
  logic        m_pm  [2];
  logic        m_sel [2];

  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "0": seg_of = 7'b1000000;
      "1": seg_of = 7'b1111001;
      "2": seg_of = 7'b0100100;
      "3": seg_of = 7'b0110000;
      "4": seg_of = 7'b0011001;
      "5": seg_of = 7'b0010010;
      "6": seg_of = 7'b0000010;
      "7": seg_of = 7'b1111000;
      "8": seg_of = 7'b0000000;
      "9": seg_of = 7'b0010000;
      "-": seg_of = 7'b0111111;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic string disp(input int unsigned h);
    string s;
    if (h > 11) return "--";
    if (h == 0) return "12";
    s = $sformatf("%02d", h);
`ifdef HOUR_LEAD_BLANK_EN
    if (s[0] == "0") s[0] = " ";
`endif
    return s;
  endfunction

  task automatic tick(input logic r, input logic [3:0] h, input string tag);
    exp_t        e;
    exp_t        got;
    string       d;
    logic        np;
    logic [6:0]  es;
    logic [1:0]  ea;
    logic        ed;
    logic [10:0] obs;
    reset   = r;
    hour_in = h;
    for (int unsigned k = 0; k < 2; k++) begin
      e.tag  = tag;
      e.inst = k;
      if (r) begin
        e.exp     = {7'h7F, 1'b1, 2'b11, 1'b0};
        m_hour[k] = 0;
        m_pm[k]   = 1'b0;
        m_cnt[k]  = 0;
        m_sel[k]  = 1'b0;
      end else begin
        d  = disp(m_hour[k]);
        np = m_pm[k] ^ ((m_hour[k] == 11) && (h == 4'd0));
        if (!m_sel[k]) begin
          es = seg_of(d[1]); ea = 2'b10; ed = ~m_pm[k];
        end else begin
          es = seg_of(d[0]); ea = 2'b01; ed = 1'b1;
        end
        e.exp     = {es, ed, ea, np};
        m_pm[k]   = np;
        m_hour[k] = h;
        if (m_cnt[k] == div_k[k] - 1) begin
          m_cnt[k] = 0;
          m_sel[k] = ~m_sel[k];
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      got = sb.pop_front();
      obs = (got.inst == 0) ? {seg_a, dp_a, an_a, pm_a} : {seg_b, dp_b, an_b, pm_b};
      checks++;
      assert (obs === got.exp) else begin
        errors++;
        $error("FAIL %s inst%0d: observed seg/dp/an/pm=%b expected %b", got.tag, got.inst, obs, got.exp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   toggles;
    logic prev_pm;
    int   guard;

    @(negedge clk);
    repeat (3) tick(1'b1, 4'd0, "reset_hold");

    // Code 0 shows "12"; tens appears on edge 5 for SCAN_DIV=4
    repeat (8) tick(1'b0, 4'd0, "code0_12");

    repeat (8) tick(1'b0, 4'd7, "code7_scan");

    // First wrap sets PM, dp lights on the ones slot
    tick(1'b0, 4'd10, "wrap1_10");
    tick(1'b0, 4'd11, "wrap1_11");
    tick(1'b0, 4'd0,  "wrap1_0");
    repeat (8) tick(1'b0, 4'd0, "pm_dp_on");
    for (int unsigned c = 1; c < 12; c++) tick(1'b0, 4'(c), "walk_to_11");
    tick(1'b0, 4'd0, "wrap2_0");
    repeat (8) tick(1'b0, 4'd0, "pm_back_am");

    // Backward step, hold at 11, invalid code, then 0: no PM change
    repeat (3) tick(1'b0, 4'd11, "hold_11");
    repeat (8) tick(1'b0, 4'd13, "invalid_13");
    repeat (8) tick(1'b0, 4'd0, "after_invalid");
    repeat (4) tick(1'b0, 4'd15, "invalid_15");

    // Reach PM, then reset mid-scan on the tens slot with scan_cnt=2
    tick(1'b0, 4'd11, "pre_rst_11");
    tick(1'b0, 4'd0,  "pre_rst_wrap");
    guard = 0;
    while (!(m_sel[0] == 1'b1 && m_cnt[0] == 2) && guard < 16) begin
      tick(1'b0, 4'd0, "pre_rst_align");
      guard++;
    end
    checks++;
    assert (m_pm[0] == 1'b1 && guard < 16) else begin
      errors++;
      $error("FAIL mid_scan_setup: observed guard=%0d expected <16 with pm set", guard);
    end
    tick(1'b1, 4'd0, "mid_scan_reset");
    repeat (8) tick(1'b0, 4'd0, "post_reset_scan");

    // Full sweep: exactly one PM toggle, at the final wrap
    toggles = 0;
    prev_pm = pm_a;
    for (int unsigned c = 0; c < 12; c++) begin
      for (int unsigned n = 0; n < 8; n++) begin
        tick(1'b0, 4'(c), "sweep");
        if (pm_a !== prev_pm) toggles++;
        prev_pm = pm_a;
      end
    end
    repeat (8) begin
      tick(1'b0, 4'd0, "sweep_wrap");
      if (pm_a !== prev_pm) toggles++;
      prev_pm = pm_a;
    end
    checks++;
    assert (toggles == 1) else begin
      errors++;
      $error("FAIL sweep_pm_toggles: observed %0d expected 1", toggles);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hour_disp_drv.md
Name: hour_disp_drv

Overview:
- Downstream consumer of the mod-12 hour counter (count 0..11).
- Registers the hour code and maps it to 12-hour display form: code 0 shows "12", codes 1..11 show "01".."11".
- Tracks AM/PM by detecting the 11->0 wrap.
- Time-multiplexes two active-low common-anode 7-segment digits for the board display.

Parameters:
- SCAN_DIV, 1000, clocks per digit slot; legal range >= 1. Scan counter width is $clog2(SCAN_DIV), minimum 1 bit.

Ports:
- clk      input   1  system clock
- reset    input   1  synchronous, active-high reset
- hour_in  input   4  hour code from the counter; 0..11 valid, 12..15 invalid
- seg      output  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- dp       output  1  decimal point, active-low
- an       output  2  digit enables, active-low; an[0] = ones, an[1] = tens
- pm       output  1  1 = PM, 0 = AM

Behaviour:
- Clock is clk. reset is synchronous and active-high.
- Reset state:
  - hour_q = 0, pm = 0, scan_cnt = 0, digit_sel = 0.
  - seg = 7'h7F, dp = 1, an = 2'b11 (all dark).
- Input register: hour_q <= hour_in on every non-reset edge.
- Digit mapping, computed from hour_q:
  - code 0: tens = 1, ones = 2.
  - codes 1..9: tens = 0, ones = code.
  - code 10: tens = 1, ones = 0.
  - code 11: tens = 1, ones = 1.
  - codes 12..15: both digits show dash, seg = 7'b0111111.
- Segment encodings (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. On the edge where it equals SCAN_DIV-1 it wraps to 0 and digit_sel toggles.
  - SCAN_DIV = 1 toggles digit_sel every cycle.
- Output register, updated every non-reset edge from pre-edge digit_sel and hour_q:
  - digit_sel = 0: an = 2'b10, seg = ones pattern, dp = ~pm.
  - digit_sel = 1: an = 2'b01, seg = tens pattern, dp = 1.
  - Exactly one an bit is low at any time after the first post-reset edge.
- Latency: hour_in sampled at edge N appears on seg at edge N+1, provided the relevant digit is selected.
- AM/PM:
  - pm toggles on an edge where hour_q == 11 and hour_in == 0 (wrap detected).
  - pm updates on the same edge as hour_q; dp reflects the new pm one edge later.
  - 11 -> invalid -> 0: no toggle.
  - 11 held: no toggle.
  - 0 -> 11 (backward step): no toggle.
  - Invalid codes never change pm.
- Reset mid-scan: all state returns to reset values on that edge. The scan restarts with the ones digit on the first edge after reset is released.
- No handshake; hour_in is assumed synchronous to clk.

Optional Feature:
- Macro: HOUR_LEAD_BLANK_EN.
- Defined: a tens digit of 0 (codes 1..9) drives the blank pattern 1111111 instead of the "0" pattern; an still enables the tens slot.
- Undefined: the tens digit of codes 1..9 shows "0" (1000000).
- Dash display for invalid codes is unaffected in both builds.

Test Plan:
1. Reset with SCAN_DIV = 4, hold 3 cycles, release. Before release: seg = 7F, an = 11, dp = 1, pm = 0. First edge after release: an = 10, seg = 0100100 ("2", code 0 -> "12"). Edge 5 after release: an = 01, seg = 1111001.
2. hour_in = 7 held, SCAN_DIV = 1. Ones slot seg = 1111000. Tens slot seg = 1000000 (macro off) or 1111111 (macro on). an alternates 10/01 every cycle.
3. hour_in steps 10 -> 11 -> 0. pm goes 0 -> 1 on the 11->0 edge. The following ones-slot output has dp = 0 and digits "12". A second full 11->0 wrap returns pm to 0.
4. hour_in = 11, then 13, then 0. Both digits show 0111111 while the code is 13. pm stays 0. Display returns to "12" after the code goes to 0.
5. Assert reset while scan_cnt = 2 on the tens slot with pm = 1. Next edge: all outputs at reset values, pm = 0. After release, the ones slot is shown first.
6. Sweep hour_in 0..11, one code per 2*SCAN_DIV cycles, SCAN_DIV = 4. Captured digit pairs equal 12, 01..11 in order. Exactly one pm toggle occurs, at the final wrap to 0.
